// File: rtl/seven_segment_reader_if.sv
// Seven-segment link: segment pattern plus common cathode from the source,
// decoded code and status flags back from the reader.
interface seven_segment_reader_if;
  logic       seg_a;
  logic       seg_b;
  logic       seg_c;
  logic       seg_d;
  logic       seg_e;
  logic       seg_f;
  logic       seg_g;
  logic       catodo_comum_dsp;
  logic [2:0] code_out;
  logic       code_valid;
  logic       range_err;
  logic       invalid;
  logic       blank;

  modport master (
    output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, catodo_comum_dsp,
    input  code_out, code_valid, range_err, invalid, blank
  );

  modport slave (
    input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, catodo_comum_dsp,
    output code_out, code_valid, range_err, invalid, blank
  );
endinterface

// File: rtl/seven_segment_reader.sv
// Recovers a 3-bit code from a synchronized seven-segment pattern once it has
// held steady for STABLE_CYCLES samples; flags 'E', blank and unknown glyphs.
module seven_segment_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seven_segment_reader_if.slave  seg_bus
);

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  typedef enum logic {SETTLE = 1'b0, LOCKED = 1'b1} state_t;

  typedef struct packed {
    logic [2:0] code;
    logic       glyph;
    logic       rerr;
    logic       inv;
    logic       blank;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] pat);
    dec_t d;
    d = '0;
    case (pat)
      7'b1111110: begin d.code = 3'd0; d.glyph = 1'b1; end
      7'b0110000: begin d.code = 3'd1; d.glyph = 1'b1; end
      7'b1101101: begin d.code = 3'd2; d.glyph = 1'b1; end
      7'b1111001: begin d.code = 3'd3; d.glyph = 1'b1; end
      7'b1001111: begin d.code = 3'd4; d.glyph = 1'b1; d.rerr = 1'b1; end
      7'b0000000: d.blank = 1'b1;
      default:    d.inv   = 1'b1;
    endcase
    return d;
  endfunction

  logic [7:0] r_sync_p0;
  logic [7:0] r_sync_p1;
  logic [6:0] w_pat;

  // Stage p0/p1: two-flop synchronizer on {cathode, a..g}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= {seg_bus.catodo_comum_dsp, seg_bus.seg_a, seg_bus.seg_b,
                    seg_bus.seg_c, seg_bus.seg_d, seg_bus.seg_e,
                    seg_bus.seg_f, seg_bus.seg_g};
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_pat = r_sync_p1[7] ? 7'd0 : r_sync_p1[6:0];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_cand;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_differ;
  logic       w_accept;

  // Stage p2: stability qualification of the synchronized pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SETTLE;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_pat;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_differ = (w_pat != r_cand);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_differ)
      w_cnt_nxt = 4'd1;
    else if (r_cnt < STABLE_C)
      w_cnt_nxt = r_cnt + 4'd1;
  end

  // A fresh pattern (reload) can accept immediately when STABLE_CYCLES is 1.
  assign w_accept = ((r_state == SETTLE) || w_differ) && (w_cnt_nxt == STABLE_C);

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)
      w_state_nxt = LOCKED;
    else if (w_differ)
      w_state_nxt = SETTLE;
  end

  dec_t       w_dec;
  logic [2:0] r_code;
  logic       r_vld;
  logic       r_rerr;
  logic       r_inv;
  logic       r_blank;
  logic [2:0] w_code_nxt;
  logic       w_vld_nxt;
  logic       w_rerr_nxt;
  logic       w_inv_nxt;
  logic       w_blank_nxt;

  assign w_dec = decode(w_pat);

  always_comb begin
    w_code_nxt  = r_code;
    w_vld_nxt   = 1'b0;
    w_rerr_nxt  = r_rerr;
    w_inv_nxt   = r_inv;
    w_blank_nxt = r_blank;
    if (w_accept) begin
      if (w_dec.glyph)
        w_code_nxt = w_dec.code;
      w_vld_nxt   = w_dec.glyph;
      w_rerr_nxt  = w_dec.rerr;
      w_inv_nxt   = w_dec.inv;
      w_blank_nxt = w_dec.blank;
    end
  end

  // Stage p3: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code  <= 3'd0;
      r_vld   <= 1'b0;
      r_rerr  <= 1'b0;
      r_inv   <= 1'b0;
      r_blank <= 1'b1;
    end else begin
      r_code  <= w_code_nxt;
      r_vld   <= w_vld_nxt;
      r_rerr  <= w_rerr_nxt;
      r_inv   <= w_inv_nxt;
      r_blank <= w_blank_nxt;
    end
  end

  assign seg_bus.code_out   = r_code;
  assign seg_bus.code_valid = r_vld;
  assign seg_bus.range_err  = r_rerr;
  assign seg_bus.invalid    = r_inv;
  assign seg_bus.blank      = r_blank;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Directed bench for seven_segment_reader with a run-length reference model
// compared against the DUT outputs on every falling edge.
module tb_seven_segment_reader;

  localparam int S = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_pulse;

  seven_segment_reader_if bus ();

  seven_segment_reader #(.STABLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic cath, input logic [6:0] p);
    {bus.seg_a, bus.seg_b, bus.seg_c, bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g} = p;
    bus.catodo_comum_dsp = cath;
  endtask

  // Reference model: the pattern seen at edge k is the input present at edge
  // k-2 (forced blank by the cathode); a pattern is accepted on the edge its
  // run of identical samples since reset (or since the last change) reaches S.
  logic [6:0] glyph_tbl [5] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b1001111};
  logic [7:0] in_hist [$];
  logic [6:0] p_hist  [$];
  logic [2:0] m_code;
  logic       m_valid, m_rerr, m_inv, m_blank;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_hist.delete();
      p_hist.delete();
      m_code  <= 3'd0;
      m_valid <= 1'b0;
      m_rerr  <= 1'b0;
      m_inv   <= 1'b0;
      m_blank <= 1'b1;
    end else begin : step
      logic [7:0] old;
      logic [6:0] p;
      int run;
      int gi;
      p = 7'd0;
      if (in_hist.size() >= 2) begin
        old = in_hist[in_hist.size()-2];
        p = old[7] ? 7'd0 : old[6:0];
      end
      in_hist.push_back({bus.catodo_comum_dsp, bus.seg_a, bus.seg_b, bus.seg_c,
                         bus.seg_d, bus.seg_e, bus.seg_f, bus.seg_g});
      p_hist.push_back(p);
      run = 0;
      for (int i = p_hist.size() - 1; i >= 0; i--) begin
        if (p_hist[i] != p || run > S) break;
        run++;
      end
      m_valid <= 1'b0;
      if (run == S) begin
        gi = -1;
        for (int g = 0; g < 5; g++) if (glyph_tbl[g] == p) gi = g;
        if (p == 7'd0) begin
          m_blank <= 1'b1; m_rerr <= 1'b0; m_inv <= 1'b0;
        end else if (gi < 0) begin
          m_blank <= 1'b0; m_rerr <= 1'b0; m_inv <= 1'b1;
        end else begin
          m_code  <= gi[2:0];
          m_valid <= 1'b1;
          m_rerr  <= (gi == 4);
          m_inv   <= 1'b0;
          m_blank <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk)
    chk("model", {bus.code_out, bus.code_valid, bus.range_err, bus.invalid, bus.blank},
                 {m_code, m_valid, m_rerr, m_inv, m_blank});

  always @(posedge clk) begin
    #1;
    if (bus.code_valid === 1'b1) n_pulse++;
  end

  initial begin : stim
    int p0;
    n_checks = 0; n_pass = 0; n_pulse = 0;
    rst_n = 1'b0;
    drive(1'b0, 7'b0000000);
    repeat (3) @(negedge clk);
    chk("rst_code", bus.code_out, 3'b000);
    chk("rst_valid", bus.code_valid, 1'b0);
    chk("rst_blank", bus.blank, 1'b1);
    chk("rst_rerr", bus.range_err, 1'b0);
    chk("rst_inv", bus.invalid, 1'b0);
    rst_n = 1'b1;

    // All segments off: stays blank, no pulse
    repeat (12) @(negedge clk);
    chk("blank_pulses", n_pulse, 0);
    chk("blank_hold", bus.blank, 1'b1);
    chk("blank_code", bus.code_out, 3'b000);

    // 1101101 -> code 2 on edge 6, single pulse
    drive(1'b0, 7'b1101101);
    repeat (5) @(negedge clk);
    chk("c2_early", bus.code_valid, 1'b0);
    @(negedge clk);
    chk("c2_valid", bus.code_valid, 1'b1);
    chk("c2_code", bus.code_out, 3'b010);
    chk("c2_blank", bus.blank, 1'b0);
    p0 = n_pulse;
    repeat (20) @(negedge clk);
    chk("c2_nopulse", n_pulse, p0);

    // 0110000 for 3 cycles is rejected; 1111001 accepted 6 edges later
    drive(1'b0, 7'b0110000);
    repeat (3) @(negedge clk);
    drive(1'b0, 7'b1111001);
    p0 = n_pulse;
    repeat (5) @(negedge clk);
    chk("c3_early", bus.code_valid, 1'b0);
    chk("c3_not1", bus.code_out, 3'b010);
    @(negedge clk);
    chk("c3_valid", bus.code_valid, 1'b1);
    chk("c3_code", bus.code_out, 3'b011);
    repeat (10) @(negedge clk);
    chk("c3_once", n_pulse, p0 + 1);

    // 'E' then an unknown glyph
    drive(1'b0, 7'b1001111);
    repeat (6) @(negedge clk);
    chk("e_valid", bus.code_valid, 1'b1);
    chk("e_code", bus.code_out, 3'b100);
    chk("e_rerr", bus.range_err, 1'b1);
    drive(1'b0, 7'b0111111);
    p0 = n_pulse;
    repeat (6) @(negedge clk);
    chk("inv_flag", bus.invalid, 1'b1);
    chk("inv_rerr", bus.range_err, 1'b0);
    chk("inv_code", bus.code_out, 3'b100);
    repeat (3) @(negedge clk);
    chk("inv_nopulse", n_pulse, p0);

    // Dark display forces blank; enabling it reveals code 0
    drive(1'b1, 7'b1111110);
    p0 = n_pulse;
    repeat (8) @(negedge clk);
    chk("dark_blank", bus.blank, 1'b1);
    chk("dark_inv", bus.invalid, 1'b0);
    chk("dark_nopulse", n_pulse, p0);
    drive(1'b0, 7'b1111110);
    repeat (5) @(negedge clk);
    chk("lit_early", bus.code_valid, 1'b0);
    @(negedge clk);
    chk("lit_valid", bus.code_valid, 1'b1);
    chk("lit_code", bus.code_out, 3'b000);
    chk("lit_blank", bus.blank, 1'b0);

    // One-cycle glitch back to the same glyph must re-qualify and pulse again
    repeat (3) @(negedge clk);
    p0 = n_pulse;
    drive(1'b0, 7'b1111001);
    @(negedge clk);
    drive(1'b0, 7'b1111110);
    repeat (10) @(negedge clk);
    chk("glitch_repulse", n_pulse, p0 + 1);
    chk("glitch_code", bus.code_out, 3'b000);

    // Asynchronous reset while code_valid is high
    drive(1'b0, 7'b1101101);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    chk("ar_pre_valid", bus.code_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", bus.code_valid, 1'b0);
    chk("ar_blank", bus.blank, 1'b1);
    chk("ar_code", bus.code_out, 3'b000);
    chk("ar_flags", {bus.range_err, bus.invalid}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("ar_early", bus.code_valid, 1'b0);
    @(negedge clk);
    chk("ar_requal", bus.code_valid, 1'b1);
    chk("ar_code2", bus.code_out, 3'b010);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
